// File: rtl/mul_seq_shift_add_if.sv
// rtl/mul_seq_shift_add_if.sv - operand/product handshake bundle for mul_seq_shift_add (SIGNED_MUL_EN adds sgn)
interface mul_seq_shift_add_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
`ifdef SIGNED_MUL_EN
   logic               sgn;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] y;

   modport slave (
`ifdef SIGNED_MUL_EN
      input  sgn,
`endif
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y
   );

   modport master (
`ifdef SIGNED_MUL_EN
      output sgn,
`endif
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y
   );
endinterface

// File: rtl/mul_seq_shift_add.sv
// rtl/mul_seq_shift_add.sv - iterative shift-and-add WIDTH x WIDTH multiplier; SIGNED_MUL_EN enables signed mode
module mul_seq_shift_add #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   mul_seq_shift_add_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [2*WIDTH-1:0]   y_q;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [CW-1:0]        cnt;
   logic                 last;

`ifdef SIGNED_MUL_EN
   logic neg;
   logic neg_in;

   // Magnitudes are taken as unsigned WIDTH-bit values so the most negative operand still fits.
   always_comb begin
      a_mag  = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
      b_mag  = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
      neg_in = bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
   end
`else
   always_comb begin
      a_mag = bus.a;
      b_mag = bus.b;
   end
`endif

   always_comb begin
      acc_sum = acc + (mplier[0] ? mcand : '0);
      last    = (cnt == CW'(WIDTH - 1));
`ifdef SIGNED_MUL_EN
      prod_fix = neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
`else
      prod_fix = acc_sum;
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         y_q    <= '0;
`ifdef SIGNED_MUL_EN
         neg    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
`ifdef SIGNED_MUL_EN
                  neg    <= neg_in;
`endif
               end
            end
            BUSY: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // The last add lands in y directly, so no extra cycle is spent moving acc.
               if (last) y_q <= prod_fix;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_q;
endmodule

// File: tb/tb_mul_seq_shift_add.sv
// tb/tb_mul_seq_shift_add.sv - directed and random scoreboard bench for mul_seq_shift_add
module tb_mul_seq_shift_add;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [2*W-1:0] exp_q[$];

   mul_seq_shift_add_if #(.WIDTH(W)) bus ();

   mul_seq_shift_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] av, input logic [W-1:0] bv,
                                               input logic sv);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      if (sv) begin
         sa = {{W{av[W-1]}}, av};
         sb = {{W{bv[W-1]}}, bv};
         return sa * sb;
      end
      return {{W{1'b0}}, av} * {{W{1'b0}}, bv};
   endfunction

   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input int hold, input string tag);
      int lat;
      lat = 0;
      while (!bus.in_ready && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.a        = av;
      bus.b        = bv;
`ifdef SIGNED_MUL_EN
      bus.sgn      = sv;
`endif
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      exp_q.push_back(ref_prod(av, bv, sv));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      check({tag, " busy"}, 32'(bus.in_ready), 32'd0);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(W));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, " hold y"}, 32'(bus.y), 32'(exp_q[0]));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check({tag, " y"}, 32'(bus.y), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, " back idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
`ifdef SIGNED_MUL_EN
      bus.sgn      = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset y", 32'(bus.y), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(8'd255, 8'd255, 1'b0, 0, "max");
      check("max const", 32'(ref_prod(8'd255, 8'd255, 1'b0)), 32'h0000FE01);
      do_op(8'd0, 8'd173, 1'b0, 0, "zero");
      do_op(8'd1, 8'd1, 1'b0, 0, "one");
      do_op(8'd13, 8'd11, 1'b0, 5, "stall");

      bus.a = 8'd200; bus.b = 8'd100; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", 32'(bus.out_valid), 32'd0);
      check("midreset y", 32'(bus.y), 32'd0);
      check("midreset in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("midreset no output", 32'(seen), 32'd0);
      do_op(8'd7, 8'd9, 1'b0, 0, "after reset");

`ifdef SIGNED_MUL_EN
      do_op(8'h80, 8'h80, 1'b1, 0, "s -128*-128");
      check("s const1", 32'(ref_prod(8'h80, 8'h80, 1'b1)), 32'h00004000);
      do_op(8'hFD, 8'd5, 1'b1, 1, "s -3*5");
      do_op(8'd127, 8'hFF, 1'b1, 0, "s 127*-1");
      do_op(8'h80, 8'd2, 1'b0, 0, "u 0x80*2");
`endif

      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(posedge clk);
         #1;
`ifdef SIGNED_MUL_EN
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
`else
         do_op(W'($urandom), W'($urandom), 1'b0, int'($urandom_range(0, 3)), "rand");
`endif
      end
      check("scoreboard empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
